// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start-bit qualification, mid-bit data sampling
// and stop-bit check, all paced by a shared N_TICKS-per-bit oversampling tick.
module uart_rx_controller #(
  parameter int N_BITS  = 8,
  parameter int N_TICKS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              rx,
  output logic              rx_done,
  output logic [N_BITS-1:0] data_out,
  output logic              frame_error,
  output logic              busy
);

  localparam int TW = (N_TICKS > 2) ? $clog2(N_TICKS) : 1;
  localparam int BW = (N_BITS  > 1) ? $clog2(N_BITS)  : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(N_TICKS / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(N_TICKS - 1);
  localparam logic [BW-1:0] WORD_LAST = BW'(N_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [TW-1:0]     tick_cnt, tick_cnt_next;
  logic [BW-1:0]     bit_cnt, bit_cnt_next;
  logic [N_BITS-1:0] shreg, shreg_next;
  logic [N_BITS-1:0] data_out_next;
  logic              frame_error_next;
  logic              rx_done_next;
  logic              rx_meta, rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      frame_error <= 1'b0;
      rx_done     <= 1'b0;
    end else begin
      state       <= state_next;
      tick_cnt    <= tick_cnt_next;
      bit_cnt     <= bit_cnt_next;
      shreg       <= shreg_next;
      data_out    <= data_out_next;
      frame_error <= frame_error_next;
      rx_done     <= rx_done_next;
    end
  end

  always_comb begin
    state_next       = state;
    tick_cnt_next    = tick_cnt;
    bit_cnt_next     = bit_cnt;
    shreg_next       = shreg;
    data_out_next    = data_out;
    frame_error_next = frame_error;
    rx_done_next     = 1'b0;
    unique case (state)
      IDLE: begin
        // Start edge is taken without waiting for a tick.
        if (!rx_s) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == HALF_LAST) begin
            if (!rx_s) begin
              state_next    = DATA;
              tick_cnt_next = '0;
              bit_cnt_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_next = '0;
            shreg_next    = {rx_s, shreg[N_BITS-1:1]};
            if (bit_cnt == WORD_LAST) state_next = STOP;
            else                      bit_cnt_next = bit_cnt + BW'(1);
          end else begin
            tick_cnt_next = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            data_out_next    = shreg;
            frame_error_next = ~rx_s;
            rx_done_next     = 1'b1;
            state_next       = IDLE;
          end else begin
            tick_cnt_next = tick_cnt + TW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed plus randomized frames against a queue-based frame model of the
// UART receiver; tick is generated every 4 clocks unless paused.
module tb_uart_rx_controller;

  localparam int NB = 8;
  localparam int NT = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tick  = 1'b0;
  logic          rx    = 1'b1;
  logic          rx_done;
  logic [NB-1:0] data_out;
  logic          frame_error;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [NB:0] exp_q[$];      // {frame_error, data} per expected rx_done
  int          done_tick_q[$];
  int          done_cnt   = 0;
  int          tick_total = 0;
  logic        tick_en    = 1'b1;
  logic        prev_done  = 1'b0;
  logic [NB:0] e_mon;
  int          div        = 0;

  uart_rx_controller #(.N_BITS(NB), .N_TICKS(NT)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .rx          (rx),
    .rx_done     (rx_done),
    .data_out    (data_out),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      @(negedge clock);
      div  = (div + 1) % 4;
      tick = tick_en && (div == 0);
    end
  end

  always @(posedge clock) if (tick) tick_total++;

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rx_done must match the oldest expected frame.
  always @(negedge clock) begin
    if (rx_done === 1'b1) begin
      done_cnt++;
      done_tick_q.push_back(tick_total);
      check("rx_done_width", {31'd0, prev_done}, 32'd0);
      check("rx_done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, e_mon[NB-1:0]});
        check("frame_error", {31'd0, frame_error}, {31'd0, e_mon[NB]});
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    prev_done = rx_done;
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clock);
      if (tick) k++;
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    @(negedge clock);
    rx = b;
    wait_ticks(n);
  endtask

  // A low stop bit is held only past mid-bit so the line is high again
  // before any re-detected start would be qualified.
  task automatic send_frame(input logic [NB-1:0] d, input logic stop);
    exp_q.push_back({~stop, d});
    drive_bit(1'b0, NT);
    for (int i = 0; i < NB; i++) drive_bit(d[i], NT);
    if (stop) drive_bit(1'b1, NT);
    else begin
      drive_bit(1'b0, NT / 2 + 2);
      drive_bit(1'b1, NT / 2 - 2);
    end
  endtask

  initial begin
    int            d0, idx;
    logic [NB-1:0] d;
    logic          s;

    // Reset state
    repeat (4) @(negedge clock);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, 2 * NT);

    // Clean frame 0xA5
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1, NT);
    check("a5_done_count", done_cnt - d0, 32'd1);
    check("a5_busy_after", {31'd0, busy}, 32'd0);

    // Short low glitch in IDLE
    d0 = done_cnt;
    drive_bit(1'b0, 1);
    check("glitch_busy_start", {31'd0, busy}, 32'd1);
    wait_ticks(4);
    drive_bit(1'b1, 10);
    check("glitch_busy_idle", {31'd0, busy}, 32'd0);
    check("glitch_no_done", done_cnt - d0, 32'd0);
    check("glitch_data_kept", {24'd0, data_out}, 32'hA5);
    drive_bit(1'b1, NT);

    // Framing error then a clean frame
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b1, NT);
    check("fe_flag_set", {31'd0, frame_error}, 32'd1);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, NT);
    check("fe_flag_clear", {31'd0, frame_error}, 32'd0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    idx = done_tick_q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1, NT);
    check("b2b_done_count", done_tick_q.size(), idx + 2);
    if (done_tick_q.size() == idx + 2)
      check("b2b_tick_spacing", done_tick_q[idx+1] - done_tick_q[idx], NT * 10);

    // Reset during data bit 4 of 0x55
    d0 = done_cnt;
    d  = 8'h55;
    drive_bit(1'b0, NT);
    for (int i = 0; i < 4; i++) drive_bit(d[i], NT);
    drive_bit(d[4], NT / 2);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data_out", {24'd0, data_out}, 32'd0);
    check("abort_frame_error", {31'd0, frame_error}, 32'd0);
    drive_bit(1'b1, 2 * NT);
    check("abort_no_done", done_cnt - d0, 32'd0);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1, NT);

    // Tick paused for 100 clocks mid-DATA
    d0 = done_cnt;
    d  = 8'hC3;
    exp_q.push_back({1'b0, d});
    drive_bit(1'b0, NT);
    for (int i = 0; i < 3; i++) drive_bit(d[i], NT);
    drive_bit(d[3], 5);
    tick_en = 1'b0;
    repeat (100) @(negedge clock);
    check("pause_busy", {31'd0, busy}, 32'd1);
    check("pause_no_done", done_cnt - d0, 32'd0);
    tick_en = 1'b1;
    wait_ticks(NT - 5);
    for (int i = 4; i < NB; i++) drive_bit(d[i], NT);
    drive_bit(1'b1, NT);
    drive_bit(1'b1, NT);
    check("pause_done_count", done_cnt - d0, 32'd1);

    // Random frames with random stop bits and gaps
    for (int f = 0; f < 8; f++) begin
      d = NB'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, s);
      drive_bit(1'b1, s ? NT * $urandom_range(0, 2) : NT * $urandom_range(1, 2));
    end
    drive_bit(1'b1, 2 * NT);

    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

UART receive sequencer driven by the shared 16x-oversampling baud tick from the baud rate generator. It watches the serial input, qualifies the start bit at mid-bit, samples N_BITS data bits LSB-first at mid-bit, checks the stop bit, and presents the received byte with a one-cycle done strobe. It sits between the board RX pin and the receive FIFO/host-interface logic of the MIPS debug UART.

## Interface
- N_BITS, 8: data bits per frame.
- N_TICKS, 16: baud ticks per bit; must be even and ≥4.
- clock  in  1  system clock; every register in the block uses only this edge.
- reset  in  1  synchronous, active-high.
- tick  in  1  one-clock pulse from the baud rate generator, N_TICKS per bit period.
- rx  in  1  asynchronous serial line, idle high.
- rx_done  out  1  one-clock pulse; the frame is complete and data_out is valid.
- data_out  out  N_BITS  last received word; held until the next rx_done.
- frame_error  out  1  stop bit sampled low on the last frame; updated with each rx_done.
- busy  out  1  high in every state except IDLE.

## Operation
- rx passes through a 2-flop synchronizer (reset value 1) to produce rx_s. All decisions use rx_s.
- Registers:
  - state: IDLE, START, DATA, STOP.
  - tick_cnt: width clog2(N_TICKS).
  - bit_cnt: width clog2(N_BITS).
  - shreg: N_BITS wide.
- IDLE:
  - When rx_s==0, go to START with tick_cnt=0.
  - tick is not required for this transition.
- START:
  - Each tick: if tick_cnt==N_TICKS/2-1, act on rx_s. Otherwise tick_cnt++.
  - rx_s==0: go to DATA with tick_cnt=0 and bit_cnt=0.
  - rx_s==1: glitch. Return to IDLE and do not pulse rx_done.
- DATA:
  - Each tick: if tick_cnt==N_TICKS-1, then tick_cnt=0 and shreg={rx_s, shreg[N_BITS-1:1]}.
  - On that same tick, if bit_cnt==N_BITS-1 go to STOP; otherwise bit_cnt++.
  - On every other tick, tick_cnt++.
- STOP:
  - Each tick: if tick_cnt==N_TICKS-1, then data_out<=shreg, frame_error<=~rx_s, rx_done<=1, and go to IDLE.
  - Otherwise tick_cnt++.
- A frame with a framing error still delivers data_out and rx_done. Consumers decide whether to discard it.
- Cycles without tick never change tick_cnt, bit_cnt, shreg or state, except for the IDLE→START transition.
- Counter arithmetic is unsigned. The tick_cnt and bit_cnt compares above prevent wrap-around.

## Timing
- Reset values:
  - state: IDLE.
  - tick_cnt, bit_cnt, shreg: 0.
  - data_out: 0.
  - rx_done, frame_error, busy: 0.
  - Synchronizer flops: 1.
- Reset asserted mid-frame aborts the frame on the next edge: no rx_done, and data_out and frame_error keep their reset values.
- After reset deasserts, a line that is already low is treated as a new start bit.
- rx to rx_s latency: 2 clocks. IDLE→START is entered on the clock after rx_s falls.
- rx_done is registered. It is high for exactly one clock, the clock after the STOP mid-bit tick.
- data_out and frame_error change on the same edge that raises rx_done.
- busy is asserted from the START entry edge through the edge that returns to IDLE.
- Back-to-back frames are supported:
  - STOP exits at mid-stop-bit, so the next start edge is detected with at least N_TICKS/2 ticks of margin.
  - A new start seen in the clock right after rx_done is accepted.
- Baud accuracy assumes N_CLOCKS = CLOCK_FREQ/(BAUD*N_TICKS). At 25 MHz and 9600 baud, N_CLOCKS=162, with the mid-bit sample within ±0.5 tick.

## Test plan
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), stop=1, tick every 4 clocks → exactly one rx_done pulse, data_out=0xA5, frame_error=0, busy low after the pulse.
- rx low pulse shorter than 6 ticks in IDLE → START entered, then return to IDLE at the 8th tick; rx_done never pulses; data_out unchanged.
- Frame 0x3C with stop bit held 0 → rx_done pulses, data_out=0x3C, frame_error=1. A following clean frame 0x81 → data_out=0x81, frame_error=0.
- Back-to-back frames 0x00 then 0xFF with no idle gap between the stop bit and the next start → two rx_done pulses, exactly N_TICKS*10 ticks apart, with data 0x00 then 0xFF.
- reset asserted for one clock during data bit 4 of frame 0x55 → busy=0 and state IDLE on the next clock, with no rx_done. The next frame 0x12 is received correctly.
- tick held low for 100 clocks mid-DATA → no counter or state change; reception completes correctly once ticks resume.
